// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that sits beside the ALU in the EX stage.
// It executes MULT/MULTU/DIV/DIVU and MTHI/MTLO and holds the architectural HI/LO registers.
//
// Multiply is shift-add and divide is restoring radix-2. Each step handles one bit.
// Operands are converted to magnitudes at start. The signs are fixed up in a final FIX cycle.
// busy_o is high for DATA_W+1 cycles per op. done_o pulses for one cycle after HI/LO
// are written.
//
// Optional build macro FAST_MUL_EN: MULT/MULTU use a single-cycle combinational multiplier.
// The product is registered at start, and HI/LO are written on the next edge (busy for one
// cycle). Division is the same in both builds.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset
//   start_i  request, sampled only while idle
//   op_i     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//   a_i      rs operand (dividend / multiplicand / MTHI-MTLO data)
//   b_i      rt operand (divisor / multiplier)
//   flush_i  abort the in-flight op; in idle it drops a simultaneous start
//   busy_o   op in progress
//   done_o   one-cycle pulse: HI/LO just updated by a multiply or divide
//   hi_o     HI register
//   lo_o     LO register
module muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam int unsigned AccW = 2 * DATA_W;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier shifting out}. Divide: {remainder, quotient}.
  logic [AccW-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;   // negate product / quotient
  logic              neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic              div_zero_q, div_zero_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              signed_op;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W-1:0] mul_add;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_diff;
  logic [AccW-1:0]   prod_fix;
  logic [DATA_W-1:0] quo_raw, rem_raw, quo_fix, rem_fix;

`ifdef FAST_MUL_EN
  logic [AccW-1:0]   fast_prod;
  assign fast_prod = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
`endif

  always_comb begin
    signed_op = (op_i == OpMult) || (op_i == OpDiv);
    abs_a     = (signed_op && a_i[DATA_W-1]) ? -a_i : a_i;
    abs_b     = (signed_op && b_i[DATA_W-1]) ? -b_i : b_i;

    mul_add   = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[AccW-1:DATA_W]} + {1'b0, mul_add};
    // Trial subtract on the remainder after shifting in the next dividend bit.
    div_diff  = acc_q[AccW-1:DATA_W-1] - {1'b0, opnd_q};

    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_raw   = acc_q[DATA_W-1:0];
    rem_raw   = acc_q[AccW-1:DATA_W];
    quo_fix   = neg_res_q ? -quo_raw : quo_raw;
    rem_fix   = neg_rem_q ? -rem_raw : rem_raw;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (!flush_i && start_i) begin
          case (op_i)
            OpMult, OpMultu: begin
              is_div_d   = 1'b0;
              neg_res_d  = signed_op & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
              neg_rem_d  = 1'b0;
              div_zero_d = 1'b0;
              opnd_d     = abs_a;
`ifdef FAST_MUL_EN
              acc_d      = fast_prod;
              state_d    = StFix;
`else
              acc_d      = {{DATA_W{1'b0}}, abs_b};
              cnt_d      = CntW'(DATA_W);
              state_d    = StCalc;
`endif
            end
            OpDiv, OpDivu: begin
              is_div_d   = 1'b1;
              neg_res_d  = signed_op & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
              neg_rem_d  = signed_op & a_i[DATA_W-1];
              div_zero_d = (b_i == '0);
              opnd_d     = abs_b;
              acc_d      = {{DATA_W{1'b0}}, abs_a};
              cnt_d      = CntW'(DATA_W);
              state_d    = StCalc;
            end
            OpMthi:  hi_d = a_i;
            OpMtlo:  lo_d = a_i;
            default: ;
          endcase
        end
      end

      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            acc_d = {acc_q[AccW-2:0], 1'b0};
            if (!div_diff[DATA_W]) begin
              acc_d[AccW-1:DATA_W] = div_diff[DATA_W-1:0];
              acc_d[0]             = 1'b1;
            end
          end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StFix;
          end
        end
      end

      StFix: begin
        state_d = StIdle;
        if (!flush_i) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            // A zero divisor leaves the dividend in the remainder; only LO needs overriding.
            lo_d = div_zero_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[AccW-1:DATA_W];
            lo_d = prod_fix[DATA_W-1:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (DATA_W = 32).
// The reference model computes HI/LO with plain integer arithmetic. It tracks latency as a
// count of busy cycles. A compare process checks every output on every falling edge.
// Directed ops also check literal results and busy-cycle counts.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = W + 1;
`endif
  localparam int DivLat = W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.DATA_W(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} for a multiply/divide op.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint p;
    int sx;
    int sy;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin
        p = longint'(sx) * longint'(sy);
        return p;
      end
      3'd1: return {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Reference model state: remaining busy cycles and pending result.
  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= p_hi;
            m_lo   <= p_lo;
            m_done <= 1'b1;
          end
        end
      end else if (start && !flush) begin
        case (op)
          3'd0, 3'd1: begin
            {p_hi, p_lo} <= model_res(op, a, b);
            m_left <= MulLat;
          end
          3'd2, 3'd3: begin
            {p_hi, p_lo} <= model_res(op, a, b);
            m_left <= DivLat;
          end
          3'd4: m_hi <= a;
          3'd5: m_lo <= a;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_left != 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  // Waits (bounded) for done; counts falling edges on which busy was high.
  task automatic wait_done(output int nb, output bit got);
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input int lat);
    int nb;
    bit got;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_done(nb, got);
    chk({name, "_done"}, 64'(got), 64'(1));
    chk({name, "_lat"}, 64'(nb), 64'(lat));
    chk({name, "_hi"}, 64'(hi), 64'(eh));
    chk({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nb;
    bit got;
    // Pin the model against hand-computed values.
    chk("model_mult", model_res(3'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_div", model_res(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model_divu0", model_res(3'd3, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk_en = 1'b1;
    rst_n = 1'b1;

    // MTHI / MTLO in idle
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'(0));
    chk("mthi_done", 64'(done), 64'(0));
    start = 1'b1; op = 3'd5; a = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);

    do_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulLat);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat);
    do_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MulLat);
    do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat);
    do_op("div_pn", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DivLat);
    do_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DivLat);
    do_op("divu0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DivLat);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivLat);
    do_op("div0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DivLat);

    // DIV in flight: start of MULT ignored at cycle 5, flush at cycle 10.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hi", 64'(hi), 64'hFFFF_FFF9);
    chk("flush_lo", 64'(lo), 64'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    chk("flush_hold_lo", 64'(lo), 64'hFFFF_FFFF);

    // MTLO while busy is dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb, got);
    chk("mtlo_busy_done", 64'(got), 64'(1));
    chk("mtlo_busy_lo", 64'(lo), 64'd14);
    chk("mtlo_busy_hi", 64'(hi), 64'd2);

    // Flush in idle drops a simultaneous start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h55;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_hi", 64'(hi), 64'd2);
    chk("idle_flush_busy", 64'(busy), 64'(0));

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst_divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DivLat);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
